// File: rtl/operand_shifter_pkg.sv
// Shared types and constants for the operand-2 barrel shifter.
// Combinational helpers only; no latency.
// No flow control lives here.
package operand_shifter_pkg;

  localparam int unsigned DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

  localparam logic [1:0] SHIFT_LSL = 2'd0;
  localparam logic [1:0] SHIFT_LSR = 2'd1;
  localparam logic [1:0] SHIFT_ASR = 2'd2;
  localparam logic [1:0] SHIFT_ROR = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RS_WAIT = 2'd1,
    OUT     = 2'd2
  } state_t;

  // Rotate right by 0..31; n=0 returns the value untouched because v<<32 is zero.
  function automatic word_t ror32(word_t v, logic [4:0] n);
    logic [5:0] left;
    left = 6'd32 - {1'b0, n};
    return (v >> n) | (v << left);
  endfunction

endpackage

// File: rtl/operand_shifter_if.sv
// Request/response bundle between register bank, shifter and ALU.
// Pure wiring; no latency.
// Valid/ready on both request and result sides; rs_valid is a one-way strobe.
interface operand_shifter_if;
  import operand_shifter_pkg::*;

  logic        in_valid;
  logic        in_ready;
  word_t       operand;
  logic [1:0]  shift_type;
  logic [4:0]  shift_imm;
  logic        shift_by_reg;
  logic        carry_in;
  logic        rs_valid;
  word_t       rs_data;
  logic        out_valid;
  logic        out_ready;
  word_t       out_data;
  logic        out_carry;

  // Requester / result consumer side.
  modport master (
    output in_valid, operand, shift_type, shift_imm, shift_by_reg, carry_in,
    output rs_valid, rs_data, out_ready,
    input  in_ready, out_valid, out_data, out_carry
  );

  // Shifter stage side.
  modport slave (
    input  in_valid, operand, shift_type, shift_imm, shift_by_reg, carry_in,
    input  rs_valid, rs_data, out_ready,
    output in_ready, out_valid, out_data, out_carry
  );
endinterface

// File: rtl/operand_shifter_shift_core.sv
// ARM barrel shifter datapath: LSL/LSR/ASR/ROR/RRX for immediate and register amounts.
// Purely combinational, zero latency.
// No flow control; the caller registers the result.
// Register-amount rules are only built with OPERAND_SHIFTER_REG_AMOUNT_EN.
module shift_core
  import operand_shifter_pkg::*;
(
  input  word_t       operand,
  input  logic [1:0]  shift_type,
  input  logic [7:0]  amount,
  input  logic        is_imm,
  input  logic        carry_in,
  output word_t       data,
  output logic        carry
);

  logic [4:0]  n5;
  logic [32:0] lsl_w;
  logic [32:0] lsr_w;
  logic [32:0] asr_w;
  word_t       rot;

  assign n5 = amount[4:0];
  // Extra bit on each shift catches the last bit shifted out as the carry.
  assign lsl_w = {1'b0, operand} << n5;
  assign lsr_w = {operand, 1'b0} >> n5;
  assign asr_w = 33'($signed({operand, 1'b0}) >>> n5);
  assign rot   = ror32(operand, n5);

`ifndef OPERAND_SHIFTER_REG_AMOUNT_EN
  // Only the immediate path exists in this build.
  wire unused_reg_amount = ^{is_imm, amount[7:5]};
`endif

  // Select the result and carry according to shift type and amount encoding.
  always_comb begin
    data  = operand;
    carry = carry_in;
`ifdef OPERAND_SHIFTER_REG_AMOUNT_EN
    if (is_imm) begin
`endif
      if (n5 == 5'd0) begin
        // Zero immediates re-encode LSR/ASR #32 and RRX.
        unique case (shift_type)
          SHIFT_LSL: begin
            data  = operand;
            carry = carry_in;
          end
          SHIFT_LSR: begin
            data  = '0;
            carry = operand[31];
          end
          SHIFT_ASR: begin
            data  = {DATA_W{operand[31]}};
            carry = operand[31];
          end
          default: begin
            data  = {carry_in, operand[31:1]};
            carry = operand[0];
          end
        endcase
      end else begin
        unique case (shift_type)
          SHIFT_LSL: begin
            data  = lsl_w[31:0];
            carry = lsl_w[32];
          end
          SHIFT_LSR: begin
            data  = lsr_w[32:1];
            carry = lsr_w[0];
          end
          SHIFT_ASR: begin
            data  = asr_w[32:1];
            carry = asr_w[0];
          end
          default: begin
            data  = rot;
            carry = rot[31];
          end
        endcase
      end
`ifdef OPERAND_SHIFTER_REG_AMOUNT_EN
    end else if (amount != 8'd0) begin
      // Register amounts use the full byte; zero leaves operand and carry alone.
      unique case (shift_type)
        SHIFT_LSL: begin
          if (amount[7:5] != 3'd0) begin
            data  = '0;
            carry = (amount == 8'd32) ? operand[0] : 1'b0;
          end else begin
            data  = lsl_w[31:0];
            carry = lsl_w[32];
          end
        end
        SHIFT_LSR: begin
          if (amount[7:5] != 3'd0) begin
            data  = '0;
            carry = (amount == 8'd32) ? operand[31] : 1'b0;
          end else begin
            data  = lsr_w[32:1];
            carry = lsr_w[0];
          end
        end
        SHIFT_ASR: begin
          if (amount[7:5] != 3'd0) begin
            data  = {DATA_W{operand[31]}};
            carry = operand[31];
          end else begin
            data  = asr_w[32:1];
            carry = asr_w[0];
          end
        end
        default: begin
          // Multiples of 32 rotate back onto themselves but still expose bit 31.
          if (n5 == 5'd0) begin
            data  = operand;
            carry = operand[31];
          end else begin
            data  = rot;
            carry = rot[31];
          end
        end
      endcase
    end
`endif
  end

endmodule

// File: rtl/operand_shifter.sv
// Operand-2 stage: applies ARM shifts to the B bus and registers operand plus carry.
// Latency: 1 cycle for immediate shifts; register shifts complete on the rs_valid edge.
// Result holds while out_ready=0; a new request is taken in the cycle the result drains.
// OPERAND_SHIFTER_REG_AMOUNT_EN enables shift-by-register (RS_WAIT state and capture regs).
module operand_shifter
  import operand_shifter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  operand_shifter_if.slave bus
);

  state_t     state_q;
  state_t     state_d;
  word_t      out_data_q;
  logic       out_carry_q;
  logic       by_reg;
  logic       load_out;
  logic       capture;
  logic       accept;

  word_t      core_operand;
  logic [1:0] core_type;
  logic [7:0] core_amount;
  logic       core_is_imm;
  logic       core_carry_in;
  word_t      core_data;
  logic       core_carry;

`ifdef OPERAND_SHIFTER_REG_AMOUNT_EN
  word_t      cap_operand_q;
  logic [1:0] cap_type_q;
  logic       cap_carry_q;
  logic       in_rs_wait;

  assign by_reg     = bus.shift_by_reg;
  assign in_rs_wait = (state_q == RS_WAIT);

  // While waiting for Rs the core works on the captured request and the A-bus byte.
  assign core_operand  = in_rs_wait ? cap_operand_q : bus.operand;
  assign core_type     = in_rs_wait ? cap_type_q    : bus.shift_type;
  assign core_carry_in = in_rs_wait ? cap_carry_q   : bus.carry_in;
  assign core_amount   = in_rs_wait ? bus.rs_data[7:0] : {3'b000, bus.shift_imm};
  assign core_is_imm   = ~in_rs_wait;

  // Hold the request fields until the Rs read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_operand_q <= '0;
      cap_type_q    <= SHIFT_LSL;
      cap_carry_q   <= 1'b0;
    end else if (capture) begin
      cap_operand_q <= bus.operand;
      cap_type_q    <= bus.shift_type;
      cap_carry_q   <= bus.carry_in;
    end
  end

  wire unused_rs_data = ^bus.rs_data[31:8];
`else
  assign by_reg        = 1'b0;
  assign core_operand  = bus.operand;
  assign core_type     = bus.shift_type;
  assign core_carry_in = bus.carry_in;
  assign core_amount   = {3'b000, bus.shift_imm};
  assign core_is_imm   = 1'b1;

  wire unused_rs = ^{bus.rs_valid, bus.rs_data, bus.shift_by_reg, capture};
`endif

  shift_core u_core (
    .operand    (core_operand),
    .shift_type (core_type),
    .amount     (core_amount),
    .is_imm     (core_is_imm),
    .carry_in   (core_carry_in),
    .data       (core_data),
    .carry      (core_carry)
  );

  // Next-state and handshake decode; accept covers both IDLE and a draining OUT.
  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    capture     = 1'b0;
    accept      = 1'b0;
    bus.in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
      end
`ifdef OPERAND_SHIFTER_REG_AMOUNT_EN
      RS_WAIT: begin
        if (bus.rs_valid) begin
          load_out = 1'b1;
          state_d  = OUT;
        end
      end
`endif
      OUT: begin
        if (bus.out_ready) begin
          bus.in_ready = 1'b1;
          accept       = bus.in_valid;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (by_reg) begin
        capture = 1'b1;
        state_d = RS_WAIT;
      end else begin
        load_out = 1'b1;
        state_d  = OUT;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Result registers only move on a load, so they are stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_carry_q <= 1'b0;
    end else if (load_out) begin
      out_data_q  <= core_data;
      out_carry_q <= core_carry;
    end
  end

  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_carry = out_carry_q;

endmodule

// File: tb/tb_operand_shifter.sv
// Directed bench for operand_shifter: immediate table, register path, backpressure, reset.
// Inputs change and outputs are sampled on the falling edge.
// Register-path steps follow the build's OPERAND_SHIFTER_REG_AMOUNT_EN setting.
module tb_operand_shifter;
  import operand_shifter_pkg::*;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  operand_shifter_if bus ();

  operand_shifter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive_req(input logic [31:0] op, input logic [1:0] typ, input logic [4:0] imm,
                           input logic by_reg, input logic cin);
    bus.in_valid     = 1'b1;
    bus.operand      = op;
    bus.shift_type   = typ;
    bus.shift_imm    = imm;
    bus.shift_by_reg = by_reg;
    bus.carry_in     = cin;
  endtask

`ifdef OPERAND_SHIFTER_REG_AMOUNT_EN
  // Register request with Rs arriving one cycle after acceptance.
  task automatic reg_req(input string tag, input logic [31:0] op, input logic [1:0] typ,
                         input logic cin, input logic [31:0] rs,
                         input logic [31:0] exp_d, input logic exp_c);
    drive_req(op, typ, 5'd0, 1'b1, cin);
    tick();
    bus.in_valid = 1'b0;
    bus.rs_valid = 1'b1;
    bus.rs_data  = rs;
    tick();
    bus.rs_valid = 1'b0;
    chk({tag, "_vld"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_dat"}, bus.out_data, exp_d);
    chk({tag, "_cry"}, {31'd0, bus.out_carry}, {31'd0, exp_c});
    tick();
  endtask
`endif

  typedef struct {
    logic [31:0] op;
    logic [1:0]  typ;
    logic [4:0]  imm;
    logic        cin;
    logic [31:0] exp_d;
    logic        exp_c;
  } imm_vec_t;

  imm_vec_t imm_tab [9];

  initial begin
    n_total = 0;
    n_pass  = 0;
    imm_tab[0] = '{32'h8000_000F, SHIFT_LSL, 5'd4,  1'b0, 32'h0000_00F0, 1'b0};
    imm_tab[1] = '{32'h8000_0001, SHIFT_LSR, 5'd0,  1'b0, 32'h0000_0000, 1'b1};
    imm_tab[2] = '{32'h0000_0003, SHIFT_ROR, 5'd0,  1'b1, 32'h8000_0001, 1'b1};
    imm_tab[3] = '{32'h8000_0010, SHIFT_ASR, 5'd4,  1'b0, 32'hF800_0001, 1'b0};
    imm_tab[4] = '{32'h8000_0000, SHIFT_LSR, 5'd31, 1'b0, 32'h0000_0001, 1'b0};
    imm_tab[5] = '{32'h1234_5678, SHIFT_ROR, 5'd8,  1'b0, 32'h7812_3456, 1'b0};
    imm_tab[6] = '{32'h8000_0000, SHIFT_ASR, 5'd0,  1'b0, 32'hFFFF_FFFF, 1'b1};
    imm_tab[7] = '{32'h0000_0005, SHIFT_LSL, 5'd0,  1'b1, 32'h0000_0005, 1'b1};
    imm_tab[8] = '{32'hC000_0000, SHIFT_LSL, 5'd1,  1'b0, 32'h8000_0000, 1'b1};

    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.operand      = '0;
    bus.shift_type   = SHIFT_LSL;
    bus.shift_imm    = '0;
    bus.shift_by_reg = 1'b0;
    bus.carry_in     = 1'b0;
    bus.rs_valid     = 1'b0;
    bus.rs_data      = '0;
    bus.out_ready    = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data",  bus.out_data,           32'd0);
    chk("rst_out_carry", {31'd0, bus.out_carry}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back immediate shifts, one result per cycle.
    for (int i = 0; i < 9; i++) begin
      drive_req(imm_tab[i].op, imm_tab[i].typ, imm_tab[i].imm, 1'b0, imm_tab[i].cin);
      chk($sformatf("imm%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
      tick();
      chk($sformatf("imm%0d_vld", i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("imm%0d_dat", i), bus.out_data, imm_tab[i].exp_d);
      chk($sformatf("imm%0d_cry", i), {31'd0, bus.out_carry}, {31'd0, imm_tab[i].exp_c});
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain_idle_vld", {31'd0, bus.out_valid}, 32'd0);

`ifdef OPERAND_SHIFTER_REG_AMOUNT_EN
    // Register ASR by 40 with Rs two cycles after accept.
    drive_req(32'h8000_0000, SHIFT_ASR, 5'd0, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("rasr_wait_rdy", {31'd0, bus.in_ready},  32'd0);
    chk("rasr_wait_vld", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("rasr_wait2_vld", {31'd0, bus.out_valid}, 32'd0);
    bus.rs_valid = 1'b1;
    bus.rs_data  = 32'h0000_0028;
    tick();
    bus.rs_valid = 1'b0;
    chk("rasr_vld", {31'd0, bus.out_valid}, 32'd1);
    chk("rasr_dat", bus.out_data, 32'hFFFF_FFFF);
    chk("rasr_cry", {31'd0, bus.out_carry}, 32'd1);
    tick();

    reg_req("rlsl_0",   32'h1234_5678, SHIFT_LSL, 1'b1, 32'h0000_0100, 32'h1234_5678, 1'b1);
    reg_req("rror_32",  32'h8765_4321, SHIFT_ROR, 1'b0, 32'h0000_0020, 32'h8765_4321, 1'b1);
    reg_req("rlsl_32",  32'h0000_0001, SHIFT_LSL, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b1);
    reg_req("rlsl_33",  32'hFFFF_FFFF, SHIFT_LSL, 1'b1, 32'h0000_0021, 32'h0000_0000, 1'b0);
    reg_req("rlsr_32",  32'h8000_0000, SHIFT_LSR, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b1);
    reg_req("rlsr_4",   32'h0000_00F8, SHIFT_LSR, 1'b0, 32'h0000_0004, 32'h0000_000F, 1'b1);
`else
    // Without register amounts, shift_by_reg is ignored and the immediate is used.
    drive_req(32'h0000_0001, SHIFT_LSL, 5'd4, 1'b1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("noreg_vld", {31'd0, bus.out_valid}, 32'd1);
    chk("noreg_dat", bus.out_data, 32'h0000_0010);
    chk("noreg_cry", {31'd0, bus.out_carry}, 32'd0);
    tick();
`endif

    // Backpressure: result A held while B waits.
    bus.out_ready = 1'b0;
    drive_req(32'h0000_0001, SHIFT_LSL, 5'd1, 1'b0, 1'b0);
    tick();
    drive_req(32'h0000_0006, SHIFT_LSR, 5'd1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_vld", i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp%0d_dat", i), bus.out_data, 32'h0000_0002);
      chk($sformatf("bp%0d_rdy", i), {31'd0, bus.in_ready}, 32'd0);
      if (i < 4) tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("bp_b_vld", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_b_dat", bus.out_data, 32'h0000_0003);
    chk("bp_b_cry", {31'd0, bus.out_carry}, 32'd0);
    drive_req(32'h0000_000F, SHIFT_ROR, 5'd4, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_c_dat", bus.out_data, 32'hF000_0000);
    chk("bp_c_cry", {31'd0, bus.out_carry}, 32'd1);
    tick();

`ifdef OPERAND_SHIFTER_REG_AMOUNT_EN
    // Reset while waiting for Rs discards the captured request.
    drive_req(32'h0000_00FF, SHIFT_LSL, 5'd0, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("rw_pre_rdy", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rw_rst_vld", {31'd0, bus.out_valid}, 32'd0);
    chk("rw_rst_rdy", {31'd0, bus.in_ready},  32'd1);
    tick();
    rst_n = 1'b1;
    bus.rs_valid = 1'b1;
    bus.rs_data  = 32'h0000_0004;
    tick();
    bus.rs_valid = 1'b0;
    chk("rw_late_rs_vld", {31'd0, bus.out_valid}, 32'd0);
`else
    // Reset with a pending result discards it.
    bus.out_ready = 1'b0;
    drive_req(32'h0000_0001, SHIFT_LSL, 5'd3, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("ro_pre_vld", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ro_rst_vld", {31'd0, bus.out_valid}, 32'd0);
    chk("ro_rst_rdy", {31'd0, bus.in_ready},  32'd1);
    chk("ro_rst_dat", bus.out_data, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("ro_after_vld", {31'd0, bus.out_valid}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/operand_shifter.md
# operand_shifter

Operand-2 stage of the ARM datapath. Sits downstream of the register bank's B read bus and upstream of the ALU's second operand input. It applies the ARM barrel-shift semantics (LSL/LSR/ASR/ROR/RRX) to the B-bus value, using either an immediate amount or a register amount taken from the A bus. It returns a registered 32-bit operand plus shifter carry-out through a valid/ready handshake.

## Interface
Parameters:
- none; data width is fixed at 32.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept a request this cycle.
- operand  in  32  value from the register-bank B bus (Rm).
- shift_type  in  2  0=LSL, 1=LSR, 2=ASR, 3=ROR.
- shift_imm  in  5  immediate shift amount; ignored when shift_by_reg=1.
- shift_by_reg  in  1  amount comes from rs_data[7:0].
- carry_in  in  1  current CPSR C flag.
- rs_valid  in  1  rs_data holds Rs (A-bus read completed).
- rs_data  in  32  register-bank A bus.
- out_valid  out  1  out_data/out_carry valid.
- out_ready  in  1  ALU consumes the result.
- out_data  out  32  shifted operand.
- out_carry  out  1  shifter carry-out.

## Operation
- FSM states: IDLE, RS_WAIT, OUT.
- IDLE: in_ready=1. On in_valid:
  - shift_by_reg=0: compute the result, register it, go to OUT.
  - shift_by_reg=1: capture operand, shift_type and carry_in, then go to RS_WAIT.
- RS_WAIT: in_ready=0. On rs_valid: amount=rs_data[7:0]; compute, register the result, go to OUT. rs_valid is ignored in IDLE and OUT.
- OUT: out_valid=1. Outputs hold stable until out_ready.
  - out_ready with in_valid: accept the new request in the same cycle; go to OUT (immediate) or RS_WAIT (register).
  - out_ready without in_valid: go to IDLE.
- in_ready = (state==IDLE) | (state==OUT & out_ready).
- Immediate amount rules (amount = shift_imm):
  - LSL #0: data unchanged, carry=carry_in.
  - LSR #0: encodes LSR #32, so data=0, carry=op[31].
  - ASR #0: encodes ASR #32, so data={32{op[31]}}, carry=op[31].
  - ROR #0: RRX, so data={carry_in,op[31:1]}, carry=op[0].
  - Otherwise n in 1..31: standard shift; carry = last bit shifted out.
- Register amount rules (n = rs_data[7:0], range 0..255):
  - n=0: data unchanged, carry=carry_in, for all types.
  - LSL: n=32 gives 0 with carry=op[0]; n>32 gives 0 with carry=0.
  - LSR: n=32 gives 0 with carry=op[31]; n>32 gives 0 with carry=0.
  - ASR: n>=32 gives {32{op[31]}} with carry=op[31].
  - ROR: n[4:0]=0 (n nonzero) gives data unchanged with carry=op[31]; otherwise rotate by n[4:0] with carry=result[31].

## Timing
- Reset (async assert, sync release): state=IDLE, out_valid=0, out_data=0, out_carry=0, in_ready=1.
- Immediate latency: accepted at edge k, out_valid=1 after edge k.
- Register latency: out_valid=1 after the first edge at which rs_valid=1 in RS_WAIT.
- Throughput: one immediate shift per cycle under continuous out_ready.
- Backpressure: out_data and out_carry must not change while out_valid=1 and out_ready=0.
- Reset mid-operation: any captured request and any pending output are discarded.

## Configuration
- OPERAND_SHIFTER_REG_AMOUNT_EN defined: full behaviour as above, including the RS_WAIT state.
- Not defined:
  - shift_by_reg is ignored and every request uses the immediate path.
  - The RS_WAIT state, the capture registers and the 8-bit amount logic are not built.
  - rs_valid and rs_data remain ports but are unused.

## Structure
- shifter_pkg holds:
  - shift type constants SHIFT_LSL/LSR/ASR/ROR;
  - FSM state enum;
  - width constant 32.
- Sub-module shift_core: purely combinational (operand, type, 8-bit amount, is_imm, carry_in) -> (data, carry). It implements both amount-rule sets.
- operand_shifter holds the FSM, capture registers and output registers.

## Test plan
- LSL #4, operand 0x8000_000F, carry_in=0, immediate -> one cycle later out_data=0x0000_00F0, out_carry=0.
- LSR #0 immediate, operand 0x8000_0001 -> out_data=0, out_carry=1; ROR #0 (RRX) with carry_in=1, operand 0x0000_0003 -> 0x8000_0001, carry=1.
- Register ASR, operand 0x8000_0000, rs_valid asserted two cycles after accept with rs_data=0x0000_0028 (40) -> out_data=0xFFFF_FFFF, carry=1, valid on the cycle after rs_valid.
- Register LSL with rs_data=0x100 (low byte 0), carry_in=1, operand 0x1234_5678 -> out_data unchanged, carry=1; register ROR by 32 -> data unchanged, carry=op[31].
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> outputs stable and in_ready=0; release -> new request accepted in the same cycle and back-to-back results follow.
- Assert rst_n low while in RS_WAIT -> out_valid=0 and in_ready=1 immediately; a late rs_valid after reset produces no output.
